intrpt_prio_loader: RTL and testbench
=====================================

// Module: intrpt_prio_loader
// PURPOSE
//  APB-style initiator that programs the per-peripheral priority table of the interrupt controller.
//  On start it issues one write per slot (paddr=slot, pwdata=priority) and waits for pready on each.
//  Handles perror with a single retry and aborts on a stuck responder.
//  Sits between boot/config logic and the controller's register port.
// PARAMETERS
//  data_width  4                  priority value width; must be >= width
//  num_slave   16                 number of peripheral slots to program
//  width       $clog2(num_slave)  paddr / slot index width
//  psel_id     3'd1               value driven on psel during a transfer
//  max_wait    15                 ACCESS cycles without pready before timeout
// PORTS
//  clk       in   1           clock, all logic on posedge
//  rst       in   1           async active-high reset
//  start     in   1           1-cycle pulse, begin programming; ignored while busy=1
//  mode      in   2           sampled at start: 0 ascending, 1 descending, 2 user table, 3 reserved (treated as 0)
//  cfg_we    in   1           user-table write strobe; ignored while busy=1
//  cfg_idx   in   width       user-table slot
//  cfg_data  in   data_width  user-table priority value
//  busy      out  1           high from cycle after accepted start until done/err pulse
//  done      out  1           1-cycle pulse, all slots written OK
//  err       out  1           1-cycle pulse, sequence aborted
//  err_code  out  2           0 none, 1 duplicate prio, 2 perror after retry, 3 timeout; held until next start
//  err_idx   out  width       slot at which abort occurred; held until next start
//  psel      out  3           psel_id during SETUP/ACCESS, else 0
//  penable   out  1           high in ACCESS only
//  pwrite    out  1           high in SETUP/ACCESS (write-only initiator)
//  paddr     out  width       current slot
//  pwdata    out  data_width  priority for current slot
//  pready    in   1           responder completes ACCESS
//  perror    in   1           valid with pready; transfer failed
//  prdata    in   width       unused by this block; tie-off accepted
// BEHAVIOUR
//  Reset (any time, async): state IDLE, all outputs 0, counters 0, user table cleared to 0.
//   Mid-transfer reset drops psel/penable immediately; no done/err pulse.
//  FSM: IDLE -> (mode2) CHECK -> SETUP -> ACCESS -> SETUP(next) | DONE | ERR -> IDLE.
//  IDLE: on start latch mode; slot=0, retry=0; go CHECK if mode2 else SETUP.
//  CHECK: one slot per cycle, num_slave cycles. Keep a seen-bitmap of values.
//   If a value is already seen: ERR, err_code=1, err_idx=that slot. Else go SETUP.
//  Priority per slot i:
//   - mode0: i
//   - mode1: num_slave-1-i
//   - mode2: table[i]
//   Zero-extended / truncated to data_width.
//  SETUP (1 cycle): psel=psel_id, pwrite=1, penable=0, paddr/pwdata valid; wait counter cleared.
//  ACCESS: penable=1; paddr/pwdata/psel held stable until pready.
//  pready=1, perror=0:
//   - slot==num_slave-1: DONE
//   - else slot+1, retry=0, SETUP
//  pready=1, perror=1:
//   - retry==0: retry=1, SETUP same slot
//   - else ERR, code=2
//  No pready for max_wait consecutive ACCESS cycles: ERR, code=3, err_idx=slot.
//  DONE/ERR (1 cycle): pulse done or err, busy=0 same cycle, bus idle; next cycle IDLE.
//  Latency, modes 0/1, pready tied 1: first SETUP at start+1; done at start+2*num_slave+1.
//  Mode2 adds num_slave cycles.
//  Simultaneous start with done/err cycle: ignored. cfg_we with start same cycle: write applied, start sees old table.
//  Slot counter stops at num_slave-1; never wraps.
// TESTING
//  mode0, pready=1 -> 16 writes paddr=0..15, pwdata=0..15; done at start+33; err_code=0.
//  mode1, pready after 2 wait cycles each -> pwdata 15..0; penable stable, addr/data stable through waits; done pulse once.
//  mode2, table with slot5 == slot2 value -> no bus activity; err=1, err_code=1, err_idx=5.
//  perror on slot3 once -> slot3 re-issued, sequence completes. perror on slot3 twice -> err_code=2, err_idx=3.
//  pready held 0 at slot7 -> err after 15 ACCESS cycles, err_code=3, err_idx=7, psel=0 after.
//  rst asserted during ACCESS of slot9 -> outputs 0 asynchronously; new start restarts from slot0.

Source files
------------

// File: rtl/intrpt_prio_loader.sv
// Priority table loader for the interrupt controller.
// On a start pulse it writes one priority value per peripheral slot over an
// APB-style write-only port (paddr = slot, pwdata = priority). A transfer that
// returns perror is retried once. A responder that never raises pready aborts
// the sequence after max_wait ACCESS cycles. In user-table mode the table is
// first scanned for duplicate priorities and nothing is written if one is found.
//
// Handshake: one transfer is a single SETUP cycle (psel=psel_id, penable=0)
// followed by ACCESS cycles (penable=1). psel, paddr and pwdata stay constant
// until the responder returns pready=1. perror is sampled only together with
// pready.
module intrpt_prio_loader #(
    parameter int         data_width = 4,
    parameter int         num_slave  = 16,
    parameter int         width      = $clog2(num_slave),
    parameter logic [2:0] psel_id    = 3'd1,
    parameter int         max_wait   = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            mode,
    input  logic                  cfg_we,
    input  logic [width-1:0]      cfg_idx,
    input  logic [data_width-1:0] cfg_data,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [1:0]            err_code,
    output logic [width-1:0]      err_idx,
    output logic [2:0]            psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [width-1:0]      paddr,
    output logic [data_width-1:0] pwdata,
    input  logic                  pready,
    input  logic                  perror,
    input  logic [width-1:0]      prdata
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CHECK  = 3'd1;
    localparam logic [2:0] S_SETUP  = 3'd2;
    localparam logic [2:0] S_ACCESS = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;
    localparam logic [2:0] S_ERR    = 3'd5;

    localparam logic [width-1:0] last_slot = width'(num_slave - 1);
    localparam int               wait_w    = $clog2(max_wait + 1);
    localparam logic [wait_w-1:0] wait_last = wait_w'(max_wait - 1);

    localparam logic [1:0] code_none = 2'd0;
    localparam logic [1:0] code_dup  = 2'd1;
    localparam logic [1:0] code_perr = 2'd2;
    localparam logic [1:0] code_tout = 2'd3;

    logic [2:0]                           state;
    logic [1:0]                           mode_q;
    logic [width-1:0]                     slot;
    logic                                 retry;
    logic [wait_w-1:0]                    wait_cnt;
    logic [(2**data_width)-1:0]           seen;
    logic [1:0]                           err_code_q;
    logic [width-1:0]                     err_idx_q;
    // cfg_tab is what software writes; run_tab is the snapshot taken at start,
    // so a write landing in the same cycle as start only affects the next run.
    logic [num_slave-1:0][data_width-1:0] cfg_tab;
    logic [num_slave-1:0][data_width-1:0] run_tab;
    logic [data_width-1:0]                prio;
    logic [data_width-1:0]                chk_val;
    logic                                 bus_act;
    logic                                 unused_ok;

    // prdata is part of the port contract but a write-only initiator never reads it.
    assign unused_ok = ^prdata;

    // Priority for the current slot, derived from the mode latched at start.
    always_comb begin
        prio = data_width'(slot);
        if (mode_q == 2'd1) begin
            prio = data_width'(32'(num_slave - 1) - 32'(slot));
        end else if (mode_q == 2'd2) begin
            prio = run_tab[slot];
        end
    end

    assign chk_val = run_tab[slot];

    // User table: writes are accepted only while no sequence is running.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_tab <= '0;
        end else if (cfg_we && !busy && (int'(cfg_idx) < num_slave)) begin
            cfg_tab[cfg_idx] <= cfg_data;
        end
    end

    // Sequencer: duplicate check, per-slot bus transfers, retry and timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            mode_q     <= 2'd0;
            slot       <= '0;
            retry      <= 1'b0;
            wait_cnt   <= '0;
            seen       <= '0;
            err_code_q <= code_none;
            err_idx_q  <= '0;
            run_tab    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mode_q     <= mode;
                        slot       <= '0;
                        retry      <= 1'b0;
                        wait_cnt   <= '0;
                        seen       <= '0;
                        err_code_q <= code_none;
                        err_idx_q  <= '0;
                        run_tab    <= cfg_tab;
                        state      <= (mode == 2'd2) ? S_CHECK : S_SETUP;
                    end
                end
                S_CHECK: begin
                    if (seen[chk_val]) begin
                        err_code_q <= code_dup;
                        err_idx_q  <= slot;
                        state      <= S_ERR;
                    end else begin
                        seen[chk_val] <= 1'b1;
                        if (slot == last_slot) begin
                            slot  <= '0;
                            state <= S_SETUP;
                        end else begin
                            slot <= slot + 1'b1;
                        end
                    end
                end
                S_SETUP: begin
                    wait_cnt <= '0;
                    state    <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (pready) begin
                        if (perror) begin
                            if (!retry) begin
                                retry <= 1'b1;
                                state <= S_SETUP;
                            end else begin
                                err_code_q <= code_perr;
                                err_idx_q  <= slot;
                                state      <= S_ERR;
                            end
                        end else if (slot == last_slot) begin
                            state <= S_DONE;
                        end else begin
                            slot  <= slot + 1'b1;
                            retry <= 1'b0;
                            state <= S_SETUP;
                        end
                    end else if (wait_cnt == wait_last) begin
                        err_code_q <= code_tout;
                        err_idx_q  <= slot;
                        state      <= S_ERR;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_DONE:  state <= S_IDLE;
                S_ERR:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Outputs decode straight from state so an async reset idles the bus at once.
    assign bus_act  = (state == S_SETUP) || (state == S_ACCESS);
    assign busy     = (state == S_CHECK) || bus_act;
    assign done     = (state == S_DONE);
    assign err      = (state == S_ERR);
    assign err_code = err_code_q;
    assign err_idx  = err_idx_q;
    assign psel     = bus_act ? psel_id : 3'd0;
    assign penable  = (state == S_ACCESS);
    assign pwrite   = bus_act;
    assign paddr    = bus_act ? slot : '0;
    assign pwdata   = bus_act ? prio : '0;

endmodule

// File: tb/tb_intrpt_prio_loader.sv
// Bench for intrpt_prio_loader: a responder model that drives pready/perror,
// a scoreboard of expected {paddr, pwdata} transfers, and directed sequences.
module tb_intrpt_prio_loader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [1:0] mode = 2'd0;
    logic       cfg_we = 1'b0;
    logic [3:0] cfg_idx = 4'd0;
    logic [3:0] cfg_data = 4'd0;
    logic       busy, done, err, penable, pwrite;
    logic [1:0] err_code;
    logic [3:0] err_idx, paddr, pwdata;
    logic [2:0] psel;
    logic       pready = 1'b0;
    logic       perror = 1'b0;
    logic [3:0] prdata = 4'd0;

    intrpt_prio_loader dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_data(cfg_data),
        .busy(busy), .done(done), .err(err), .err_code(err_code), .err_idx(err_idx),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .pready(pready), .perror(perror), .prdata(prdata)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    logic [7:0] exp_q[$];
    logic [7:0] exp_v;
    logic [3:0] tab_m[16];
    int n_cmp = 0;
    int n_bad = 0;

    // responder knobs (written by stimulus only)
    int wait_cycles = 0;
    int stuck_slot  = -1;
    int err_slot    = -1;
    int err_limit   = 0;
    // monitor bookkeeping (written by monitor only)
    int perr_used = 0;
    int done_cnt  = 0;
    int err_cnt   = 0;
    int done_cyc  = 0;
    int err_cyc   = 0;
    int xfer_cnt  = 0;
    int wcnt      = 0;
    logic       in_acc = 1'b0;
    logic [3:0] hold_a, hold_d;

    int start_cyc = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_cmp++;
        if (got !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, expv, cyc);
        end
    endtask

    // ---------------- responder + monitor ----------------
    always @(negedge clk) begin
        if (done) begin done_cnt++; done_cyc = cyc; end
        if (err)  begin err_cnt++;  err_cyc  = cyc; end
        pready = 1'b0;
        perror = 1'b0;
        if (penable && !rst) begin
            if (!in_acc) begin
                hold_a = paddr;
                hold_d = pwdata;
                wcnt   = 0;
            end
            in_acc = 1'b1;
            if (stuck_slot != int'(paddr)) begin
                if (wcnt < wait_cycles) begin
                    wcnt++;
                end else begin
                    pready = 1'b1;
                    if (err_slot == int'(paddr) && perr_used < err_limit) begin
                        perror = 1'b1;
                        perr_used++;
                    end
                    check_val("hold_addr", 32'(paddr), 32'(hold_a));
                    check_val("hold_data", 32'(pwdata), 32'(hold_d));
                    check_val("psel", 32'(psel), 32'd1);
                    check_val("pwrite", 32'(pwrite), 32'd1);
                    if (exp_q.size() == 0) begin
                        check_val("sb_underflow", 32'(paddr), 32'hffff);
                    end else begin
                        exp_v = exp_q.pop_front();
                        check_val("xfer", 32'({paddr, pwdata}), 32'(exp_v));
                    end
                    xfer_cnt++;
                    in_acc = 1'b0;
                end
            end
        end else begin
            in_acc = 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    function automatic logic [7:0] exp_xfer(input int kind, input int s);
        logic [3:0] a;
        logic [3:0] d;
        a = 4'(s);
        case (kind)
            1:       d = 4'(15 - s);
            2:       d = tab_m[s];
            default: d = 4'(s);
        endcase
        return {a, d};
    endfunction

    task automatic push_seq(input int kind, input int first, input int last);
        for (int s = first; s <= last; s++) exp_q.push_back(exp_xfer(kind, s));
    endtask

    task automatic pulse_start(input logic [1:0] m);
        @(posedge clk); #1;
        start = 1'b1; mode = m; start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic cfg_write(input int idx, input logic [3:0] val);
        @(posedge clk); #1;
        cfg_we = 1'b1; cfg_idx = 4'(idx); cfg_data = val;
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic wait_finish(input int budget);
        int d0;
        int e0;
        int n;
        d0 = done_cnt; e0 = err_cnt; n = 0;
        while (done_cnt == d0 && err_cnt == e0 && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        check_val("finish_in_budget", 32'(n < budget), 32'd1);
        @(negedge clk); #1;
    endtask

    task automatic sb_drain(input string tag);
        check_val(tag, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int d0, e0, x0, n;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_psel", 32'(psel), 0);
        check_val("rst_penable", 32'(penable), 0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk); #1;
        check_val("rst_busy", 32'(busy), 0);
        check_val("rst_done_err", 32'({done, err}), 0);
        check_val("rst_bus", 32'({pwrite, paddr, pwdata}), 0);
        check_val("rst_err_regs", 32'({err_code, err_idx}), 0);

        // A: ascending, immediate pready; a start mid-run must be ignored
        d0 = done_cnt; x0 = xfer_cnt;
        push_seq(0, 0, 15);
        pulse_start(2'd0);
        check_val("A_busy", 32'(busy), 1);
        repeat (3) @(posedge clk);
        #1; start = 1'b1; mode = 2'd1;
        @(posedge clk); #1; start = 1'b0;
        wait_finish(300);
        check_val("A_done_cnt", 32'(done_cnt - d0), 1);
        check_val("A_latency", 32'(done_cyc - start_cyc), 33);
        check_val("A_xfers", 32'(xfer_cnt - x0), 16);
        check_val("A_err_code", 32'(err_code), 0);
        check_val("A_busy_after", 32'(busy), 0);
        sb_drain("A_sb_left");

        // B: descending with 2 wait states; a cfg write while busy is dropped
        for (int i = 0; i < 16; i++) begin
            tab_m[i] = 4'(15 - i);
            cfg_write(i, tab_m[i]);
        end
        wait_cycles = 2;
        d0 = done_cnt;
        push_seq(1, 0, 15);
        pulse_start(2'd1);
        repeat (5) @(posedge clk);
        #1; cfg_we = 1'b1; cfg_idx = 4'd5; cfg_data = 4'd13;
        @(posedge clk); #1; cfg_we = 1'b0;
        wait_finish(500);
        check_val("B_done_cnt", 32'(done_cnt - d0), 1);
        check_val("B_err_code", 32'(err_code), 0);
        sb_drain("B_sb_left");
        wait_cycles = 0;

        // C: user table without duplicates (slot5 must still hold 10)
        d0 = done_cnt;
        push_seq(2, 0, 15);
        pulse_start(2'd2);
        wait_finish(300);
        check_val("C_done_cnt", 32'(done_cnt - d0), 1);
        check_val("C_latency", 32'(done_cyc - start_cyc), 49);
        sb_drain("C_sb_left");

        // D: duplicate priority in slot5 (same as slot2)
        tab_m[5] = tab_m[2];
        cfg_write(5, tab_m[5]);
        e0 = err_cnt; x0 = xfer_cnt;
        pulse_start(2'd2);
        wait_finish(300);
        check_val("D_err_cnt", 32'(err_cnt - e0), 1);
        check_val("D_err_code", 32'(err_code), 1);
        check_val("D_err_idx", 32'(err_idx), 5);
        check_val("D_err_latency", 32'(err_cyc - start_cyc), 7);
        check_val("D_no_xfers", 32'(xfer_cnt - x0), 0);

        // E: permutation table; cfg write in the start cycle uses the old table
        for (int i = 0; i < 16; i++) begin
            tab_m[i] = 4'((i * 7 + 3) % 16);
            cfg_write(i, tab_m[i]);
        end
        d0 = done_cnt;
        push_seq(2, 0, 15);
        @(posedge clk); #1;
        cfg_we = 1'b1; cfg_idx = 4'd0; cfg_data = tab_m[1];
        start = 1'b1; mode = 2'd2; start_cyc = cyc;
        @(posedge clk); #1;
        cfg_we = 1'b0; start = 1'b0;
        tab_m[0] = tab_m[1];
        wait_finish(300);
        check_val("E_done_cnt", 32'(done_cnt - d0), 1);
        check_val("E_err_code", 32'(err_code), 0);
        sb_drain("E_sb_left");

        // F: single perror on slot3 -> retried, completes
        err_slot = 3; err_limit = perr_used + 1;
        d0 = done_cnt; x0 = xfer_cnt;
        push_seq(0, 0, 3);
        push_seq(0, 3, 15);
        pulse_start(2'd0);
        wait_finish(300);
        check_val("F_done_cnt", 32'(done_cnt - d0), 1);
        check_val("F_xfers", 32'(xfer_cnt - x0), 17);
        check_val("F_err_code", 32'(err_code), 0);
        sb_drain("F_sb_left");

        // G: perror twice on slot3 -> abort
        err_limit = perr_used + 2;
        e0 = err_cnt;
        push_seq(0, 0, 3);
        push_seq(0, 3, 3);
        pulse_start(2'd0);
        wait_finish(300);
        check_val("G_err_cnt", 32'(err_cnt - e0), 1);
        check_val("G_err_code", 32'(err_code), 2);
        check_val("G_err_idx", 32'(err_idx), 3);
        sb_drain("G_sb_left");
        err_slot = -1;

        // H: stuck responder at slot7 -> timeout
        stuck_slot = 7;
        e0 = err_cnt;
        push_seq(0, 0, 6);
        pulse_start(2'd0);
        wait_finish(300);
        check_val("H_err_cnt", 32'(err_cnt - e0), 1);
        check_val("H_err_code", 32'(err_code), 3);
        check_val("H_err_idx", 32'(err_idx), 7);
        check_val("H_err_latency", 32'(err_cyc - start_cyc), 31);
        check_val("H_psel_after", 32'(psel), 0);
        repeat (4) @(negedge clk);
        check_val("H_code_held", 32'(err_code), 3);
        sb_drain("H_sb_left");
        stuck_slot = -1;

        // I: reserved mode behaves as ascending; err_code cleared by start
        d0 = done_cnt;
        push_seq(0, 0, 15);
        pulse_start(2'd3);
        check_val("I_code_cleared", 32'(err_code), 0);
        wait_finish(300);
        check_val("I_done_cnt", 32'(done_cnt - d0), 1);
        sb_drain("I_sb_left");

        // J: async reset during ACCESS of slot9
        stuck_slot = 9;
        d0 = done_cnt; e0 = err_cnt;
        push_seq(0, 0, 8);
        pulse_start(2'd0);
        n = 0;
        while (!(penable && paddr == 4'd9) && n < 200) begin
            @(negedge clk); #1;
            n++;
        end
        check_val("J_reach_slot9", 32'(n < 200), 1);
        #1 rst = 1'b1;
        #1;
        check_val("J_rst_psel", 32'(psel), 0);
        check_val("J_rst_penable", 32'(penable), 0);
        check_val("J_rst_busy", 32'(busy), 0);
        check_val("J_rst_bus", 32'({paddr, pwdata}), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        stuck_slot = -1;
        @(negedge clk); #1;
        check_val("J_no_pulse", 32'((done_cnt - d0) + (err_cnt - e0)), 0);
        sb_drain("J_sb_left");
        d0 = done_cnt;
        push_seq(0, 0, 15);
        pulse_start(2'd0);
        wait_finish(300);
        check_val("J_restart_done", 32'(done_cnt - d0), 1);
        check_val("J_restart_latency", 32'(done_cyc - start_cyc), 33);
        sb_drain("J_restart_sb_left");
        // table was cleared by reset: slot1 duplicates slot0
        e0 = err_cnt;
        pulse_start(2'd2);
        wait_finish(300);
        check_val("J_tab_clr_err", 32'(err_cnt - e0), 1);
        check_val("J_tab_clr_code", 32'(err_code), 1);
        check_val("J_tab_clr_idx", 32'(err_idx), 1);
        check_val("J_tab_clr_latency", 32'(err_cyc - start_cyc), 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
